// File: rtl/riscv_pkg.sv
// riscv_pkg: shared M-extension types for the EX-stage multiply/divide unit.
package riscv_pkg;
   typedef enum logic [2:0] {
      MUL    = 3'd0,
      MULH   = 3'd1,
      MULHSU = 3'd2,
      MULHU  = 3'd3,
      DIV    = 3'd4,
      DIVU   = 3'd5,
      REM    = 3'd6,
      REMU   = 3'd7
   } muldiv_op_e;
   typedef enum logic [1:0] {IDLE, CALC, DONE} muldiv_state_e;
   function automatic logic muldiv_is_div(muldiv_op_e op);
      return op[2];
   endfunction
endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one BITS_PER_CYCLE iteration of shift-add multiply or restoring divide.
module muldiv_step #(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic              is_div_i,
   input  logic [2*XLEN-1:0] acc_i,
   input  logic [XLEN-1:0]   opnd_i,
   output logic [2*XLEN-1:0] acc_o
);
   logic [2*XLEN-1:0] acc;
   logic [XLEN:0]     r, s;
   logic              ge;
   // acc holds {remainder, dividend/quotient} for divide and {product_hi, multiplier/product_lo} for multiply
   always_comb begin
      acc = acc_i;
      r   = '0;
      s   = '0;
      ge  = 1'b0;
      for (int i = 0; i < BITS_PER_CYCLE; i++) begin
         r   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
         ge  = r >= {1'b0, opnd_i};
         r   = ge ? r - {1'b0, opnd_i} : r;
         s   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opnd_i} : '0);
         acc = is_div_i ? {r[XLEN-1:0], acc[XLEN-2:0], ge} : {s, acc[XLEN-1:1]};
      end
   end
   assign acc_o = acc;
endmodule

// File: rtl/ex_muldiv_unit.sv
// ex_muldiv_unit: iterative RV32M/RV64M multiply/divide unit with valid/ready request and response.
// Optional MULDIV_EARLY_OUT_EN: zero-operand multiplies and divide special cases skip CALC.
module ex_muldiv_unit
   import riscv_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1,
   parameter int TAG_W          = 5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [XLEN-1:0]  req_a,
   input  logic [XLEN-1:0]  req_b,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_result,
   output logic [TAG_W-1:0] resp_tag,
   output logic             busy
);
   localparam int N  = XLEN / BITS_PER_CYCLE;
   localparam int CW = $clog2(N + 1);

   // Sign-corrects the magnitude result and overrides it with the divide special cases.
   function automatic logic [XLEN-1:0] final_res(muldiv_op_e op, logic [XLEN-1:0] a, logic as, logic bs,
                                                 logic dz, logic ovf, logic [2*XLEN-1:0] acc);
      logic [2*XLEN-1:0] p;
      logic [XLEN-1:0]   q, r;
      p = (as ^ bs) ? -acc : acc;
      q = (as ^ bs) ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      r = as ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
      case (op)
         MUL:                return p[XLEN-1:0];
         MULH, MULHSU, MULHU: return p[2*XLEN-1:XLEN];
         DIV, DIVU:          return dz ? '1 : ovf ? a : q;
         default:            return dz ? a : ovf ? '0 : r;
      endcase
   endfunction

   muldiv_state_e     state_q;
   muldiv_op_e        op_q, op_i;
   logic [TAG_W-1:0]  tag_q;
   logic [XLEN-1:0]   a_q, opnd_q, res_q, a_mag, b_mag, early_res;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [CW-1:0]     cnt_q;
   logic              as_q, bs_q, dz_q, ovf_q, as_i, bs_i, dz_i, ovf_i, early;

   assign op_i      = muldiv_op_e'(req_op);
   assign as_i      = (op_i == MULH || op_i == MULHSU || op_i == DIV || op_i == REM) && req_a[XLEN-1];
   assign bs_i      = (op_i == MULH || op_i == DIV || op_i == REM) && req_b[XLEN-1];
   assign a_mag     = as_i ? -req_a : req_a;
   assign b_mag     = bs_i ? -req_b : req_b;
   assign dz_i      = muldiv_is_div(op_i) && req_b == '0;
   assign ovf_i     = (op_i == DIV || op_i == REM) && req_a == {1'b1, {(XLEN-1){1'b0}}} && req_b == '1;
   assign early_res = final_res(op_i, req_a, as_i, bs_i, dz_i, ovf_i, '0);
`ifdef MULDIV_EARLY_OUT_EN
   assign early = dz_i || ovf_i || (!muldiv_is_div(op_i) && (req_a == '0 || req_b == '0));
`else
   assign early = 1'b0;
`endif

   muldiv_step #(.XLEN(XLEN), .BITS_PER_CYCLE(BITS_PER_CYCLE)) u_step (
      .is_div_i(muldiv_is_div(op_q)),
      .acc_i   (acc_q),
      .opnd_i  (opnd_q),
      .acc_o   (acc_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         op_q    <= MUL;
         tag_q   <= '0;
         a_q     <= '0;
         opnd_q  <= '0;
         res_q   <= '0;
         acc_q   <= '0;
         cnt_q   <= '0;
         as_q    <= 1'b0;
         bs_q    <= 1'b0;
         dz_q    <= 1'b0;
         ovf_q   <= 1'b0;
      end else if (flush) begin
         state_q <= IDLE;
      end else begin
         case (state_q)
            IDLE: if (req_valid) begin
               op_q    <= op_i;
               tag_q   <= req_tag;
               a_q     <= req_a;
               opnd_q  <= b_mag;
               acc_q   <= {{XLEN{1'b0}}, a_mag};
               cnt_q   <= CW'(N);
               as_q    <= as_i;
               bs_q    <= bs_i;
               dz_q    <= dz_i;
               ovf_q   <= ovf_i;
               state_q <= early ? DONE : CALC;
               if (early) res_q <= early_res;
            end
            CALC: begin
               acc_q <= acc_d;
               cnt_q <= cnt_q - 1'b1;
               if (cnt_q == CW'(1)) begin
                  res_q   <= final_res(op_q, a_q, as_q, bs_q, dz_q, ovf_q, acc_d);
                  state_q <= DONE;
               end
            end
            default: if (resp_ready) state_q <= IDLE;
         endcase
      end
   end

   assign req_ready   = state_q == IDLE && !flush;
   assign resp_valid  = state_q == DONE;
   assign busy        = state_q != IDLE;
   assign resp_result = res_q;
   assign resp_tag    = tag_q;
endmodule

// File: tb/tb_ex_muldiv_unit.sv
// tb_ex_muldiv_unit: directed and randomized checks of ex_muldiv_unit against an arithmetic reference model.
module tb_ex_muldiv_unit;
   localparam int XLEN = 32;
   localparam int LAT  = 33;

   logic            clk = 1'b0, reset = 1'b1, flush = 1'b0;
   logic            req_valid = 1'b0, req_ready, resp_valid, resp_ready = 1'b0, busy;
   logic [2:0]      req_op = '0;
   logic [XLEN-1:0] req_a = '0, req_b = '0, resp_result;
   logic [4:0]      req_tag = '0, resp_tag;
   int              n_tests = 0, n_fail = 0;

   ex_muldiv_unit dut (
      .clk(clk), .reset(reset), .flush(flush),
      .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
      .req_a(req_a), .req_b(req_b), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_result(resp_result), .resp_tag(resp_tag), .busy(busy)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      longint      sa, sb;
      logic [63:0] ua, ub, p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = {32'd0, a};
      ub = {32'd0, b};
      p  = '0;
      case (op)
         3'd0: begin p = sa * sb; return p[31:0]; end
         3'd1: begin p = sa * sb; return p[63:32]; end
         3'd2: begin p = sa * longint'(ub); return p[63:32]; end
         3'd3: begin p = ua * ub; return p[63:32]; end
         3'd4: return b == 0 ? 32'hFFFF_FFFF : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? a : 32'(sa / sb);
         3'd5: return b == 0 ? 32'hFFFF_FFFF : 32'(ua / ub);
         3'd6: return b == 0 ? a : (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ? 32'd0 : 32'(sa % sb);
         default: return b == 0 ? a : 32'(ua % ub);
      endcase
   endfunction

   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'($urandom_range(0, 40));
         default: return 32'($urandom);
      endcase
   endfunction

   task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
      @(negedge clk);
      check("accept_ready", req_ready, 1'b1);
      req_valid = 1'b1;
      req_op    = op;
      req_a     = a;
      req_b     = b;
      req_tag   = tag;
      @(negedge clk);
      req_valid = 1'b0;
      req_op    = 3'($urandom);
      req_a     = $urandom;
      req_b     = $urandom;
      req_tag   = 5'($urandom);
   endtask

   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input int hold);
      logic [4:0] tag;
      int         n;
      tag = 5'($urandom);
      issue(op, a, b, tag);
      n = 1;
      while (!resp_valid && n < 100) begin
         resp_ready = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      resp_ready = 1'b0;
      check("latency", n, LAT);
      check("result", resp_result, exp);
      check("tag", resp_tag, tag);
      repeat (hold) begin
         @(negedge clk);
         check("hold_result", resp_result, exp);
         check("hold_tag", resp_tag, tag);
         check("hold_valid_ready", {resp_valid, req_ready}, 2'b10);
      end
      resp_ready = 1'b1;
      @(negedge clk);
      resp_ready = 1'b0;
      check("back_idle", {resp_valid, busy, req_ready}, 3'b001);
   endtask

   task automatic no_resp(input string tag, input int cycles);
      logic seen;
      seen = 1'b0;
      repeat (cycles) begin
         @(negedge clk);
         seen |= resp_valid;
      end
      check(tag, seen, 1'b0);
   endtask

   initial begin
      logic [2:0]  op;
      logic [31:0] a, b;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_outputs", {req_ready, resp_valid, busy}, 3'b100);
      check("rst_result", resp_result, 32'd0);
      check("rst_tag", resp_tag, 5'd0);

      run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 5);
      run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
      run_op(3'd4, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 1);
      run_op(3'd6, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 0);
      run_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, 0);
      run_op(3'd4, 32'hFFFF_FFEC, 32'd0, 32'hFFFF_FFFF, 0);
      run_op(3'd6, 32'hFFFF_FFEC, 32'd0, 32'hFFFF_FFEC, 0);
      run_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 0);
      run_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
      run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 0);
      run_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);

      issue(3'd4, 32'd1000, 32'd7, 5'd9);
      repeat (9) @(negedge clk);
      flush = 1'b1;
      #1 check("flush_ready_low", req_ready, 1'b0);
      @(negedge clk);
      flush = 1'b0;
      check("flush_idle", {busy, resp_valid}, 2'b00);
      no_resp("flush_no_resp", 40);

      @(negedge clk);
      flush     = 1'b1;
      req_valid = 1'b1;
      req_op    = 3'd0;
      req_a     = 32'd3;
      req_b     = 32'd3;
      #1 check("flush_req_ready", req_ready, 1'b0);
      @(negedge clk);
      req_valid = 1'b0;
      flush     = 1'b0;
      check("flush_no_accept", busy, 1'b0);
      no_resp("flush_req_no_resp", 40);

      issue(3'd0, 32'd12345, 32'd678, 5'd17);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("midrst_state", {req_ready, resp_valid, busy}, 3'b100);
      check("midrst_result", resp_result, 32'd0);
      check("midrst_tag", resp_tag, 5'd0);
      no_resp("midrst_no_resp", 40);

      for (int i = 0; i < 300; i++) begin
         op = 3'($urandom);
         a  = pick();
         b  = pick();
         run_op(op, a, b, ref_res(op, a, b), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
